// File: rtl/fx2fp_pkg.sv
// Shared types and width helpers for the fixed-point to float converter.
package fx2fp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StNorm,
        StRound,
        StDone
    } state_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Shift count runs 0..IN_W-1
    function automatic int unsigned cnt_w(input int unsigned in_w);
        return $clog2(in_w);
    endfunction

    // Signed exponent working width, with room for the rounding carry and negative values
    function automatic int unsigned exp_calc_w(input int unsigned in_w, input int unsigned exp_w);
        return $clog2(in_w + (1 << exp_w)) + 2;
    endfunction

endpackage

// File: rtl/fx2fp_seq_if.sv
// Start/done coprocessor bus between the converter and its requester.
interface fx2fp_seq_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 16
);
    logic             start;
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dout;
    logic             done;
    logic             busy;
    logic             ovf;
    logic             unf;
    logic             inexact;

    modport master (output start, din, input dout, done, busy, ovf, unf, inexact);
    modport slave  (input start, din, output dout, done, busy, ovf, unf, inexact);
endinterface

// File: rtl/fx2fp_pack.sv
// Combinational rounding and packing of a normalised magnitude into {sign, exp, man}.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fx2fp_pack
    import fx2fp_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned MAN_W  = 10,
    localparam int unsigned CNT_W = cnt_w(IN_W),
    localparam int unsigned OUT_W = 1 + EXP_W + MAN_W
) (
    input  logic             sign_i,
    input  logic [IN_W-1:0]  mag_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [OUT_W-1:0] dout_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             inexact_o
);
    localparam int unsigned E_W = exp_calc_w(IN_W, EXP_W);
    localparam int unsigned FB  = IN_W - 1;
    // Bits below the hidden one, zero padded so guard/sticky always exist
    localparam int unsigned XW  = FB + MAN_W + 2;

    logic [XW-1:0]         ext;
    logic [MAN_W-1:0]      man;
    logic                  guard;
    logic                  sticky;
    logic signed [E_W-1:0] e;

    always_comb begin
        ext    = {mag_i[FB-1:0], {(MAN_W + 2){1'b0}}};
        man    = ext[XW-1 -: MAN_W];
        guard  = ext[XW-1-MAN_W];
        sticky = |ext[XW-2-MAN_W:0];
        e      = $signed(E_W'(IN_W - 1 - FRAC_W + bias(EXP_W))) - $signed(E_W'(cnt_i));
`ifdef ROUND_NEAREST_EN
        if (guard && (sticky || man[0])) begin
            if (&man) begin
                man = '0;
                e   = e + $signed(E_W'(1));
            end else begin
                man = man + MAN_W'(1);
            end
        end
`endif
        dout_o    = {sign_i, e[EXP_W-1:0], man};
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        inexact_o = guard | sticky;
        if (mag_i == '0) begin
            dout_o    = '0;
            inexact_o = 1'b0;
        end else if (e >= $signed(E_W'((1 << EXP_W) - 1))) begin
            dout_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_o  = 1'b1;
        end else if (e <= $signed(E_W'(0))) begin
            dout_o    = {sign_i, {(EXP_W + MAN_W){1'b0}}};
            unf_o     = 1'b1;
            inexact_o = 1'b1;
        end
    end
endmodule

// File: rtl/fx2fp_seq.sv
// Sequential signed fixed-point to float converter, one normalising shift per cycle.
// Rounding mode is set by the ROUND_NEAREST_EN macro inside fx2fp_pack.
module fx2fp_seq
    import fx2fp_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned MAN_W  = 10
) (
    input  logic        clk,
    input  logic        reset,
    fx2fp_seq_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_w(IN_W);
    localparam int unsigned OUT_W = 1 + EXP_W + MAN_W;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [IN_W-1:0]    din_q, din_d;
    logic               sign_q, sign_d;
    logic [IN_W-1:0]    mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inexact_q, inexact_d;

    logic [OUT_W-1:0]   pk_dout;
    logic               pk_ovf, pk_unf, pk_inexact;
    logic               accept;
    logic [IN_W-1:0]    neg;

    fx2fp_pack #(
        .IN_W   (IN_W),
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W)
    ) u_pack (
        .sign_i    (sign_q),
        .mag_i     (mag_q),
        .cnt_i     (cnt_q),
        .dout_o    (pk_dout),
        .ovf_o     (pk_ovf),
        .unf_o     (pk_unf),
        .inexact_o (pk_inexact)
    );

    assign accept = bus.start & ~start_q & ((state_q == StIdle) | (state_q == StDone));

    always_comb begin
        state_d   = state_q;
        start_d   = bus.start;
        din_d     = din_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;
        neg       = -din_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    din_d   = bus.din;
                    done_d  = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sign_d  = din_q[IN_W-1];
                mag_d   = din_q[IN_W-1] ? neg : din_q;
                cnt_d   = '0;
                // Zero skips normalisation but still passes through ROUND, which packs +0
                state_d = (mag_d == '0) ? StRound : StNorm;
            end
            StNorm: begin
                if (mag_q[IN_W-1]) begin
                    state_d = StRound;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRound: begin
                dout_d    = pk_dout;
                ovf_d     = pk_ovf;
                unf_d     = pk_unf;
                inexact_d = pk_inexact;
                done_d    = 1'b1;
                state_d   = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            din_q     <= '0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            din_q     <= din_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == StLoad) | (state_q == StNorm) | (state_q == StRound);
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.inexact = inexact_q;
endmodule
